// File: rtl/key_rom_loader.sv
// -----------------------------------------------------------------------------
// key_rom_loader
//
// Fetches a run-time-selectable number of key bytes from a synchronous ROM
// into a packed key array. The RC4 KSA/PRGA datapath downstream consumes
// key_arr once finished is high.
//
// Each byte costs ROM_LATENCY+2 clocks:
//   READ (1) -> WAIT (ROM_LATENCY) -> STORE (1).
// The ROM address walks from BASE_ADDR and wraps modulo 2^ROM_ADDR_W.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   level load request, sampled only in IDLE and DONE
//   key_len    in   bytes to load (0 or >KEY_LENGTH means KEY_LENGTH),
//                   sampled when start is accepted
//   rom_out    in   ROM read data
//   address    out  registered ROM address
//   key_arr    out  packed loaded key; byte slot b is key_arr[b*ROM_WIDTH +: ROM_WIDTH]
//   finished   out  high while in DONE
//   busy       out  high in READ/WAIT/STORE
//   state_tap  out  current state encoding (IDLE=0 READ=1 WAIT=2 STORE=3 DONE=4)
//   checksum   out  XOR of all bytes stored in the current load
//                   (present only when KEY_ROM_LOADER_CHECKSUM_EN is defined)
//
// Optional feature macro: KEY_ROM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module key_rom_loader #(
  parameter int KEY_LENGTH  = 32,
  parameter int ROM_WIDTH   = 8,
  parameter int ROM_ADDR_W  = 5,
  parameter int ROM_LATENCY = 1,
  parameter int BASE_ADDR   = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [$clog2(KEY_LENGTH+1)-1:0]    key_len,
  input  logic [ROM_WIDTH-1:0]               rom_out,
  output logic [ROM_ADDR_W-1:0]              address,
  output logic [KEY_LENGTH*ROM_WIDTH-1:0]    key_arr,
  output logic                               finished,
  output logic                               busy,
  output logic [2:0]                         state_tap
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [ROM_WIDTH-1:0]               checksum
`endif
);

  localparam int LEN_W = $clog2(KEY_LENGTH + 1);
  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  localparam logic [ROM_ADDR_W-1:0] BASE     = ROM_ADDR_W'(BASE_ADDR);
  localparam logic [LEN_W-1:0]      MAX_LEN  = LEN_W'(KEY_LENGTH);
  localparam logic [LEN_W-1:0]      TOP_SLOT = LEN_W'(KEY_LENGTH - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  len;
  logic [CNT_W-1:0]  count;

  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  slot;
  logic              last_byte;

  // Out-of-range requests (0 or more than the array holds) load the full key.
  always_comb begin
    eff_len = key_len;
    if (key_len == '0 || key_len > MAX_LEN) begin
      eff_len = MAX_LEN;
    end
  end

  // Destination slot of the byte being stored.
  always_comb begin
    slot = idx;
    if (MSB_FIRST != 0) begin
      slot = TOP_SLOT - idx;
    end
  end

  assign last_byte = (idx == len - LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    finished  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (count == LAST_CNT) begin
          state_nxt = STORE;
        end
      end
      STORE: begin
        busy      = 1'b1;
        state_nxt = last_byte ? DONE : READ;
      end
      DONE: begin
        finished = 1'b1;
        // Staying here while start is held stops a level request from
        // retriggering; start must drop before the next load.
        if (!start) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign state_tap = state;

  // Datapath: address walk, wait counter, byte capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address <= BASE;
      key_arr <= '0;
      idx     <= '0;
      len     <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len     <= eff_len;
            idx     <= '0;
            key_arr <= '0;
            address <= BASE;
          end
        end
        READ: begin
          count <= '0;
        end
        WAIT: begin
          count <= count + CNT_W'(1);
        end
        STORE: begin
          for (int b = 0; b < KEY_LENGTH; b++) begin
            if (LEN_W'(b) == slot) begin
              key_arr[b*ROM_WIDTH +: ROM_WIDTH] <= rom_out;
            end
          end
          // On the last byte idx and address stay put so DONE holds them.
          if (!last_byte) begin
            idx     <= idx + LEN_W'(1);
            address <= address + ROM_ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef KEY_ROM_LOADER_CHECKSUM_EN
  // Running XOR of the bytes captured by the current load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == STORE) begin
      checksum <= checksum ^ rom_out;
    end
  end
`else
  // No checksum port or state in this build.
`endif

endmodule

// File: tb/tb_key_rom_loader.sv
module tb_key_rom_loader;

  localparam int NI = 4;
  // Per-instance configuration: 0 defaults, 1 LSB-first, 2 latency 3, 3 base 30.
  localparam int BASE_T [NI] = '{0, 0, 0, 30};
  localparam int MSB_T  [NI] = '{1, 0, 1, 1};
  localparam int LAT_T  [NI] = '{1, 1, 3, 1};

  logic         clk;
  logic         reset_n;
  logic [5:0]   key_len;
  logic         start     [NI];
  logic [7:0]   rom_out   [NI];
  logic [4:0]   address   [NI];
  logic [255:0] key_arr   [NI];
  logic         finished  [NI];
  logic         busy      [NI];
  logic [2:0]   state_tap [NI];
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
  logic [7:0]   checksum  [NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         inst;
    int         klen;
    int         sa;
    logic [7:0] ba;
    int         sb;
    logic [7:0] bb;
  } vec_t;

  typedef struct {
    logic [255:0] key;
    int           cyc;
    logic [7:0]   csum;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] alog[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_rom_loader u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .key_len(key_len),
    .rom_out(rom_out[0]), .address(address[0]), .key_arr(key_arr[0]),
    .finished(finished[0]), .busy(busy[0]), .state_tap(state_tap[0])
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum[0])
`endif
  );

  key_rom_loader #(.MSB_FIRST(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .key_len(key_len),
    .rom_out(rom_out[1]), .address(address[1]), .key_arr(key_arr[1]),
    .finished(finished[1]), .busy(busy[1]), .state_tap(state_tap[1])
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum[1])
`endif
  );

  key_rom_loader #(.ROM_LATENCY(3)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .key_len(key_len),
    .rom_out(rom_out[2]), .address(address[2]), .key_arr(key_arr[2]),
    .finished(finished[2]), .busy(busy[2]), .state_tap(state_tap[2])
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum[2])
`endif
  );

  key_rom_loader #(.BASE_ADDR(30)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start[3]), .key_len(key_len),
    .rom_out(rom_out[3]), .address(address[3]), .key_arr(key_arr[3]),
    .finished(finished[3]), .busy(busy[3]), .state_tap(state_tap[3])
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    , .checksum(checksum[3])
`endif
  );

  // ROM models: data = address + 8'h10, valid only once the address has been
  // stable for the configured latency; garbage (8'hEE) otherwise.
  for (genvar g = 0; g < NI; g++) begin : g_rom
    localparam int LAT = LAT_T[g];
    logic [4:0] pipe [3];
    always @(posedge clk) begin
      pipe[0] <= address[g];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    always_comb begin
      rom_out[g] = 8'hEE;
      if (LAT == 1) begin
        rom_out[g] = {3'b000, pipe[0]} + 8'h10;
      end else if (pipe[0] == pipe[1] && pipe[1] == pipe[2]) begin
        rom_out[g] = {3'b000, pipe[2]} + 8'h10;
      end
    end
  end

  // Address presented during each READ cycle of the base-30 instance.
  always @(negedge clk) begin
    if (state_tap[3] == 3'd1) alog.push_back(address[3]);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input int klen);
    return (klen == 0 || klen > 32) ? 32 : klen;
  endfunction

  function automatic exp_t model(input int inst, input int klen);
    exp_t e;
    logic [7:0] d;
    int slot;
    e.key  = '0;
    e.csum = 8'h00;
    for (int i = 0; i < eff_len(klen); i++) begin
      d    = 8'(((BASE_T[inst] + i) % 32) + 16);
      slot = (MSB_T[inst] != 0) ? 31 - i : i;
      e.key[slot*8 +: 8] = d;
      e.csum = e.csum ^ d;
    end
    e.cyc = eff_len(klen) * (LAT_T[inst] + 2);
    return e;
  endfunction

  task automatic finish_and_compare(input int inst, input string tag, input int cyc_in);
    int   cyc;
    exp_t e;
    cyc = cyc_in;
    while (!finished[inst] && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, "_cycles"}, 256'(cyc), 256'(e.cyc));
    check({tag, "_key"}, key_arr[inst], e.key);
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 256'(checksum[inst]), 256'(e.csum));
`endif
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    key_len = 6'(v.klen);
    start[v.inst] = 1'b1;
    sb.push_back(model(v.inst, v.klen));
    @(posedge clk); #1;
    check({tag, "_clear_on_accept"}, key_arr[v.inst], '0);
    check({tag, "_busy"}, 256'(busy[v.inst]), 256'(1));
    finish_and_compare(v.inst, tag, 0);
    check({tag, "_byte_a"}, 256'(key_arr[v.inst][v.sa*8 +: 8]), 256'(v.ba));
    check({tag, "_byte_b"}, 256'(key_arr[v.inst][v.sb*8 +: 8]), 256'(v.bb));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, {state_tap[v.inst], finished[v.inst]}, {3'd4, 1'b1});
    @(negedge clk);
    start[v.inst] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_back_idle"}, {state_tap[v.inst], finished[v.inst]}, {3'd0, 1'b0});
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{inst: 0, klen: 0,  sa: 31, ba: 8'h10, sb: 0,  bb: 8'h2F};
    vecs[1] = '{inst: 0, klen: 3,  sa: 31, ba: 8'h10, sb: 29, bb: 8'h12};
    vecs[2] = '{inst: 1, klen: 3,  sa: 0,  ba: 8'h10, sb: 2,  bb: 8'h12};
    vecs[3] = '{inst: 2, klen: 2,  sa: 31, ba: 8'h10, sb: 30, bb: 8'h11};
    vecs[4] = '{inst: 3, klen: 4,  sa: 31, ba: 8'h2E, sb: 28, bb: 8'h11};
    vecs[5] = '{inst: 0, klen: 40, sa: 31, ba: 8'h10, sb: 0,  bb: 8'h2F};
    vecs[6] = '{inst: 2, klen: 1,  sa: 31, ba: 8'h10, sb: 30, bb: 8'h00};
    vecs[7] = '{inst: 1, klen: 32, sa: 0,  ba: 8'h10, sb: 31, bb: 8'h2F};

    key_len = 6'd0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_state0", 256'(state_tap[0]), 256'(0));
    check("rst_addr0", 256'(address[0]), 256'(0));
    check("rst_addr3", 256'(address[3]), 256'(30));
    check("rst_key0", key_arr[0], '0);
    check("rst_flags0", {finished[0], busy[0]}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    alog.delete();
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Address walk of the base-30 load wraps past 31.
    check("addr_seq_len", 256'(alog.size()), 256'(4));
    if (alog.size() == 4) begin
      check("addr_seq", {alog[0], alog[1], alog[2], alog[3]},
            {5'd30, 5'd31, 5'd0, 5'd1});
    end

    // start toggling and key_len changes mid-load are ignored.
    begin
      int cyc;
      @(negedge clk);
      key_len = 6'd4;
      start[0] = 1'b1;
      sb.push_back(model(0, 4));
      @(posedge clk); #1;
      cyc = 0;
      while (!finished[0] && cyc < 400) begin
        if (cyc == 3) start[0] = 1'b0;
        if (cyc == 5) begin
          start[0] = 1'b1;
          key_len = 6'd1;
        end
        @(posedge clk); #1;
        cyc++;
      end
      finish_and_compare(0, "toggle", cyc);
      @(negedge clk);
      start[0] = 1'b0;
      @(posedge clk); #1;
    end

    // Reset asserted during WAIT of the second byte aborts at once.
    @(negedge clk);
    key_len = 6'd4;
    start[3] = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("midload_state", 256'(state_tap[3]), 256'(2));
    check("midload_addr", 256'(address[3]), 256'(31));
    check("midload_byte0", 256'(key_arr[3][255:248]), 256'(8'h2E));
    reset_n = 1'b0;
    #1;
    check("abort_key", key_arr[3], '0);
    check("abort_state", 256'(state_tap[3]), 256'(0));
    check("abort_addr", 256'(address[3]), 256'(30));
    check("abort_flags", {finished[3], busy[3]}, 2'b00);
    start[3] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 256'(state_tap[3]), 256'(0));
    run_vec('{inst: 3, klen: 2, sa: 31, ba: 8'h2E, sb: 30, bb: 8'h2F}, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
